// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller slice.
// Holds the FSM state encoding, the SPI mode constants {CPOL,CPHA} and the
// default transfer word width.
package spi_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    // SPI modes, encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage : spi_pkg

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side transfer interface of spi_xfer_ctrl.
//   start     : transfer request (honoured only while the controller is idle)
//   mode      : {CPOL,CPHA}, latched at an accepted start
//   tx_data   : word to send, latched at an accepted start
//   rx_data   : last received word, updated together with done
//   busy      : transfer in progress
//   done      : one-cycle completion pulse
//   lsb_first : bit order select, present only with SPI_XFER_LSB_FIRST_EN
// modport master = host side, modport slave = controller side.
interface spi_xfer_ctrl_if #(
    parameter int unsigned DATA_W = 8
);

    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
`ifdef SPI_XFER_LSB_FIRST_EN
    logic              lsb_first;
`endif

    modport master (
        output start,
        output mode,
        output tx_data,
`ifdef SPI_XFER_LSB_FIRST_EN
        output lsb_first,
`endif
        input  rx_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  mode,
        input  tx_data,
`ifdef SPI_XFER_LSB_FIRST_EN
        input  lsb_first,
`endif
        output rx_data,
        output busy,
        output done
    );

endinterface : spi_xfer_ctrl_if

// File: rtl/spi_shift_reg.sv
// DATA_W-bit parallel-load shift register with separate TX and RX fields.
//   clk, rst_n    : clock, async active-low reset
//   load_i        : load load_data_i into TX, clear RX
//   load_data_i   : parallel word for TX
//   tx_shift_i    : advance the TX field by one bit
//   rx_shift_i    : shift shift_in_i into the RX field
//   shift_in_i    : serial input bit
//   lsb_first_i   : direction; 0 = MSB first, 1 = LSB first
//   tx_bit_o      : current serial output bit
//   rx_data_o     : RX field contents
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              tx_shift_i,
    input  logic              rx_shift_i,
    input  logic              shift_in_i,
    input  logic              lsb_first_i,
    output logic              tx_bit_o,
    output logic [DATA_W-1:0] rx_data_o
);

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    // Next-value logic for both fields
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load_i) begin
            tx_d = load_data_i;
            rx_d = '0;
        end else begin
            if (tx_shift_i) begin
                tx_d = lsb_first_i ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
            end
            if (rx_shift_i) begin
                rx_d = lsb_first_i ? {shift_in_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], shift_in_i};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

    assign tx_bit_o  = lsb_first_i ? tx_q[0] : tx_q[DATA_W-1];
    assign rx_data_o = rx_q;

endmodule : spi_shift_reg

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller driven by an external baud-rate generator.
// Optional feature macro: SPI_XFER_LSB_FIRST_EN (adds bus.lsb_first).
//   clk, rst_n   : clock, async active-low reset
//   bus          : host interface (start/mode/tx_data in, rx_data/busy/done out)
//   brg_en       : generator enable
//   brg_sclk_en  : generator SCLK enable
//   brg_strobe   : generator half-period strobe
//   brg_rise     : generator leading reference edge pulse
//   brg_fall     : generator trailing reference edge pulse
//   mosi, miso   : serial data out / in
//   ss_n         : slave select, active low
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_xfer_ctrl_if.slave  bus,
    output logic            brg_en,
    output logic            brg_sclk_en,
    input  logic            brg_strobe,
    input  logic            brg_rise,
    input  logic            brg_fall,
    output logic            mosi,
    input  logic            miso,
    output logic            ss_n
);

    localparam int unsigned EDGES = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(EDGES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EDGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(EDGES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              brg_en_q, brg_en_d;
    logic              sclk_en_q, sclk_en_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic              load_c;
    logic              tx_shift_c;
    logic              rx_shift_c;
    logic              lsb_in_c;
    logic              tx_bit;
    logic [DATA_W-1:0] rx_word;
    logic              cpol_unused;

    // CPOL only shapes the generator's SCLK level; the controller needs CPHA
    assign cpol_unused = bus.mode[1];

`ifdef SPI_XFER_LSB_FIRST_EN
    assign lsb_in_c = bus.lsb_first;
`else
    assign lsb_in_c = 1'b0;
`endif

    // Next-state, shift control and registered-output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        load_c     = 1'b0;
        tx_shift_c = 1'b0;
        rx_shift_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // busy_q still high in the done cycle, so start is ignored there
                if (bus.start && !busy_q) begin
                    state_d = ST_SETUP;
                    load_c  = 1'b1;
                    cpha_d  = bus.mode[0];
                    lsb_d   = lsb_in_c;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (brg_strobe) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (brg_rise || brg_fall) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // First bit is already on mosi from SETUP, so the first
                    // CPHA=1 leading edge and the last CPHA=0 trailing edge
                    // must not advance it.
                    if (cpha_q) begin
                        tx_shift_c = brg_rise && (cnt_q != '0);
                        rx_shift_c = brg_fall;
                    end else begin
                        rx_shift_c = brg_rise;
                        tx_shift_c = brg_fall && (cnt_q != CNT_LAST);
                    end
                    if (cnt_q >= CNT_LAST) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (brg_strobe) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    rx_data_d = rx_word;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ss_n_d    = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE) || done_d;
        brg_en_d  = (state_d != ST_IDLE);
        sclk_en_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            brg_en_q  <= 1'b0;
            sclk_en_q <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            brg_en_q  <= brg_en_d;
            sclk_en_q <= sclk_en_d;
            rx_data_q <= rx_data_d;
        end
    end

    spi_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_c),
        .load_data_i (bus.tx_data),
        .tx_shift_i  (tx_shift_c),
        .rx_shift_i  (rx_shift_c),
        .shift_in_i  (miso),
        .lsb_first_i (lsb_q),
        .tx_bit_o    (tx_bit),
        .rx_data_o   (rx_word)
    );

    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign brg_en      = brg_en_q;
    assign brg_sclk_en = sclk_en_q;
    assign ss_n        = ss_n_q;
    assign mosi        = tx_bit;

endmodule : spi_xfer_ctrl
